// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_arb_pkg
//  Description : Shared types and constants for the packet-granular AXI-Stream
//                round-robin arbiter (axis_rr_arb, axis_rr_pick).
//                Contents: arb_state_t FSM encoding, MAX_PORTS upper bound,
//                ptr_width() helper sizing the last-winner pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    localparam int MAX_PORTS = 8;

    // Pointer width for a port index; a single-port build still gets one bit
    // so that no zero-width vectors appear anywhere.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_pick
//  Description : Combinational rotating-priority encoder. Scans requests
//                starting at last_ptr+1 and wrapping modulo N_PORTS; returns
//                the first requester as a one-hot grant.
//  Ports       : req      in  N_PORTS  request vector
//                last_ptr in  PW       index of the previous winner
//                gnt      out N_PORTS  one-hot grant (0 when no request)
//                valid    out 1        at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]            req,
    input  logic [ptr_width(N_PORTS)-1:0] last_ptr,
    output logic [N_PORTS-1:0]            gnt,
    output logic                          valid
);

    localparam int PW = ptr_width(N_PORTS);

    // One spare bit so last_ptr + k never overflows before the modulo fold.
    logic [PW:0]   w_pos;
    logic [PW-1:0] w_idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        w_pos = '0;
        w_idx = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_pos = {1'b0, last_ptr} + (PW+1)'(k);
            if (w_pos >= (PW+1)'(N_PORTS)) begin
                w_pos = w_pos - (PW+1)'(N_PORTS);
            end
            w_idx = w_pos[PW-1:0];
            if (!valid && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arb
//  Description : Packet-granular round-robin arbiter sharing one AXI-Stream
//                slave among N_PORTS masters. A grant is taken in IDLE (one
//                bubble cycle) and held until the tlast handshake; the data
//                path is a zero-latency mux of the granted port.
//  Ports       : aclk, rst (sync, active-high)
//                s_tvalid/s_tready/s_tlast [N_PORTS], s_tdata [N_PORTS*DW]
//                m_tvalid/m_tready/m_tlast, m_tdata [DW]
//                grant [N_PORTS] one-hot registered, busy (state PASS)
//                pkt_cnt [N_PORTS*CW] completed packets per port (optional)
//  Options     : AXIS_ARB_PKTCNT_EN - adds per-port wrapping packet counters
//                and the pkt_cnt port.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arb
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DW      = 32,
    parameter int CW      = 16
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [N_PORTS-1:0]      s_tvalid,
    output logic [N_PORTS-1:0]      s_tready,
    input  logic [N_PORTS*DW-1:0]   s_tdata,
    input  logic [N_PORTS-1:0]      s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DW-1:0]           m_tdata,
    output logic                    m_tlast,
    output logic [N_PORTS-1:0]      grant,
    output logic                    busy
`ifdef AXIS_ARB_PKTCNT_EN
    ,
    output logic [N_PORTS*CW-1:0]   pkt_cnt
`endif
);

    localparam int PW = ptr_width(N_PORTS);

    if (N_PORTS < 1 || N_PORTS > MAX_PORTS || CW < 1 || DW < 1) begin : g_bad_params
        $error("axis_rr_arb: parameter out of range");
    end

    arb_state_t         r_state;
    logic [N_PORTS-1:0] r_grant;
    logic [PW-1:0]      r_last_ptr;

    logic [N_PORTS-1:0] w_pick_gnt;
    logic               w_pick_valid;
    logic [PW-1:0]      w_gidx;
    logic               w_done;

    axis_rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .req      (s_tvalid),
        .last_ptr (r_last_ptr),
        .gnt      (w_pick_gnt),
        .valid    (w_pick_valid)
    );

    // Index of the currently granted port, recorded as the new last winner.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_grant[i]) begin
                w_gidx = PW'(i);
            end
        end
    end

    // Output mux; everything is quiet outside PASS so no beat moves in IDLE.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (r_state == PASS) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (r_grant[i]) begin
                    m_tvalid    = s_tvalid[i];
                    m_tdata     = s_tdata[i*DW +: DW];
                    m_tlast     = s_tlast[i];
                    s_tready[i] = m_tready;
                end
            end
        end
    end

    assign w_done = (r_state == PASS) && m_tvalid && m_tready && m_tlast;

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_last_ptr <= PW'(N_PORTS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_gnt;
                        r_state <= PASS;
                    end
                end
                PASS: begin
                    if (w_done) begin
                        r_last_ptr <= w_gidx;
                        r_grant    <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == PASS);

`ifdef AXIS_ARB_PKTCNT_EN
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_pktcnt
        logic [CW-1:0] r_cnt;

        // Free-running wrap at 2**CW-1 -> 0.
        always_ff @(posedge aclk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_done && r_grant[gi]) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign pkt_cnt[gi*CW +: CW] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_rr_arb
//  Description : Directed self-checking bench for axis_rr_arb (N_PORTS=4,
//                DW=32, CW=2). Each upstream port is a simple packet source
//                (base, packet length, total beats) that advances on its own
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 2;

    logic            aclk;
    logic            rst;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef AXIS_ARB_PKTCNT_EN
    logic [N*CW-1:0] pkt_cnt;
`endif

    axis_rr_arb #(
        .N_PORTS (N),
        .DW      (DW),
        .CW      (CW)
    ) dut (
        .aclk     (aclk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .grant    (grant),
        .busy     (busy)
`ifdef AXIS_ARB_PKTCNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_assert = 0;
    int n_fail   = 0;

    // Source model state per port.
    int          src_b   [N];
    int          src_tot [N];
    int          src_len [N];
    logic [31:0] src_base[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic src_set(input int p, input logic [31:0] base, input int len, input int tot);
        src_b[p]    = 0;
        src_base[p] = base;
        src_len[p]  = len;
        src_tot[p]  = tot;
    endtask

    task automatic set_inputs();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = (src_b[i] < src_tot[i]);
            s_tdata[i*DW +: DW]  = src_base[i] + 32'(src_b[i]);
            s_tlast[i]           = ((src_b[i] % src_len[i]) == (src_len[i] - 1));
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, then let
    // each source advance on the handshake that the next rising edge takes.
    task automatic step(input string tag, input logic r, input logic mr,
                        input logic [N-1:0] eg, input logic ev,
                        input logic [31:0] ed, input logic el);
        logic [N-1:0] hs;
        @(posedge aclk);
        #1;
        rst      = r;
        m_tready = mr;
        set_inputs();
        @(negedge aclk);
        chk({tag, " grant"},    64'(grant),    64'(eg));
        chk({tag, " busy"},     64'(busy),     64'(|eg));
        chk({tag, " m_tvalid"}, 64'(m_tvalid), 64'(ev));
        chk({tag, " m_tdata"},  64'(m_tdata),  64'(ed));
        chk({tag, " m_tlast"},  64'(m_tlast),  64'(el));
        chk({tag, " s_tready"}, 64'(s_tready), 64'(mr ? eg : '0));
        hs = s_tvalid & s_tready;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) src_b[i]++;
        end
    endtask

    task automatic do_reset(input string tag);
        for (int i = 0; i < N; i++) src_set(i, 32'h0, 1, 0);
        @(posedge aclk);
        #1;
        rst      = 1'b1;
        m_tready = 1'b1;
        set_inputs();
        repeat (4) @(posedge aclk);
        #1;
        rst = 1'b0;
        @(negedge aclk);
        chk({tag, " grant"},    64'(grant),    64'h0);
        chk({tag, " busy"},     64'(busy),     64'h0);
        chk({tag, " m_tvalid"}, 64'(m_tvalid), 64'h0);
        chk({tag, " m_tlast"},  64'(m_tlast),  64'h0);
        chk({tag, " m_tdata"},  64'(m_tdata),  64'h0);
        chk({tag, " s_tready"}, 64'(s_tready), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        for (int i = 0; i < N; i++) src_set(i, 32'h0, 1, 0);

        // Reset state.
        do_reset("reset");

        // 1: port 1 alone, 3-beat packet A0..A2.
        src_set(1, 32'hA0, 3, 3);
        step("t1 k0", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t1 k1", 0, 1, 4'b0010, 1, 32'hA0, 0);
        step("t1 k2", 0, 1, 4'b0010, 1, 32'hA1, 0);
        step("t1 k3", 0, 1, 4'b0010, 1, 32'hA2, 1);
        step("t1 k4", 0, 1, 4'b0000, 0, 32'h0,  0);

        // 2: all ports with 2-beat packets; order 0,1,2,3,0 with one bubble.
        do_reset("t2 reset");
        src_set(0, 32'h000, 2, 4);
        src_set(1, 32'h100, 2, 2);
        src_set(2, 32'h200, 2, 2);
        src_set(3, 32'h300, 2, 2);
        for (int k = 0; k < 16; k++) begin
            int ph;
            int p;
            int port;
            ph   = k % 3;
            p    = k / 3;
            port = p % 4;
            if (ph == 0) begin
                step($sformatf("t2 k%0d", k), 0, 1, 4'b0000, 0, 32'h0, 0);
            end else begin
                step($sformatf("t2 k%0d", k), 0, 1, 4'(1 << port), 1,
                     32'((port << 8) | (2 * (p / 4) + ph - 1)), (ph == 2));
            end
        end

        // 3: port 2 with m_tready toggling; s_tready[2] must mirror it.
        src_set(2, 32'hC0, 3, 3);
        step("t3 k0", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t3 k1", 0, 0, 4'b0100, 1, 32'hC0, 0);
        step("t3 k2", 0, 1, 4'b0100, 1, 32'hC0, 0);
        step("t3 k3", 0, 0, 4'b0100, 1, 32'hC1, 0);
        step("t3 k4", 0, 1, 4'b0100, 1, 32'hC1, 0);
        step("t3 k5", 0, 0, 4'b0100, 1, 32'hC2, 1);
        step("t3 k6", 0, 1, 4'b0100, 1, 32'hC2, 1);
        step("t3 k7", 0, 1, 4'b0000, 0, 32'h0,  0);
        chk("t3 beats", 64'(src_b[2]), 64'd3);

        // 4: port 3 single-beat packet, then ports 0 and 2 -> port 0 first.
        src_set(3, 32'hD0, 1, 1);
        step("t4 k0", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t4 k1", 0, 1, 4'b1000, 1, 32'hD0, 1);
        src_set(0, 32'h50, 1, 1);
        src_set(2, 32'h70, 1, 1);
        step("t4 k2", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t4 k3", 0, 1, 4'b0001, 1, 32'h50, 1);
        step("t4 k4", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t4 k5", 0, 1, 4'b0100, 1, 32'h70, 1);
        step("t4 k6", 0, 1, 4'b0000, 0, 32'h0,  0);

        // 5: reset pulse in the middle of a port 1 packet.
        src_set(1, 32'hE0, 4, 4);
        step("t5 k0", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t5 k1", 0, 1, 4'b0010, 1, 32'hE0, 0);
        src_set(0, 32'hF0, 2, 2);
        step("t5 k2", 1, 1, 4'b0010, 1, 32'hE1, 0);
        step("t5 k3", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t5 k4", 0, 1, 4'b0001, 1, 32'hF0, 0);
        step("t5 k5", 0, 1, 4'b0001, 1, 32'hF1, 1);
        step("t5 k6", 0, 1, 4'b0000, 0, 32'h0,  0);
        step("t5 k7", 0, 1, 4'b0010, 1, 32'hE2, 0);
        step("t5 k8", 0, 1, 4'b0010, 1, 32'hE3, 1);
        step("t5 k9", 0, 1, 4'b0000, 0, 32'h0,  0);

`ifdef AXIS_ARB_PKTCNT_EN
        // 6: five packets on port 0 with a 2-bit counter -> wraps to 1.
        do_reset("t6 reset");
        chk("t6 pkt_cnt reset", 64'(pkt_cnt), 64'h0);
        src_set(0, 32'h10, 1, 5);
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                step($sformatf("t6 k%0d", k), 0, 1, 4'b0000, 0, 32'h0, 0);
            end else begin
                step($sformatf("t6 k%0d", k), 0, 1, 4'b0001, 1, 32'(32'h10 + k / 2), 1);
            end
        end
        step("t6 k10", 0, 1, 4'b0000, 0, 32'h0, 0);
        chk("t6 pkt_cnt", 64'(pkt_cnt), 64'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
